// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite subordinate backed by a word-addressed SRAM array.
// Programmable wait states, little-endian byte-lane writes, two-cycle ERROR
// response for out-of-range, oversized or misaligned transfers.
module ahb_lite_sram_slave #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic                  HWRITE,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic [1:0]            HRESP,
   output logic                  HREADY
);

   localparam int unsigned LANES = 4;
   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
   localparam int unsigned CNT_W = 4;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);
   localparam logic [CNT_W-1:0]      WAIT_LOAD  = CNT_W'(WAIT_STATES - 1);

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                 state_q;
   logic                   hready_q;
   logic [1:0]             hresp_q;
   logic                   wr_q;
   logic [IDX_W-1:0]       idx_q;
   logic [LANES-1:0]       lanes_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

   logic                   active_c;
   logic                   misalign_c;
   logic                   legal_c;
   logic [LANES-1:0]       lanes_c;

   // Burst type and protection carry no behaviour; HTRANS[0] only separates IDLE/BUSY or NONSEQ/SEQ.
   logic                   unused_bus_bits;
   assign unused_bus_bits = ^{HTRANS[0], HBURST, HPROT};

   // Address-phase decode: transfer request, legality and little-endian lane enables.
   always_comb begin
      active_c   = HSEL && HTRANS[1];
      misalign_c = ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
      legal_c    = (HADDR < ADDR_LIMIT) && (HSIZE <= 3'd2) && !misalign_c;
      lanes_c    = 4'b1111;
      case (HSIZE)
         3'd0:    lanes_c = 4'(4'b0001 << HADDR[1:0]);
         3'd1:    lanes_c = HADDR[1] ? 4'b1100 : 4'b0011;
         default: lanes_c = 4'b1111;
      endcase
   end

   // Transfer FSM with registered HREADY/HRESP, latched address phase and SRAM write port.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         hready_q <= 1'b1;
         hresp_q  <= RESP_OKAY;
         wr_q     <= 1'b0;
         idx_q    <= '0;
         lanes_q  <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         // Write commits on the edge that ends the write data phase.
         if (state_q == ST_DATA && wr_q) begin
            for (int b = 0; b < LANES; b++) begin
               if (lanes_q[b]) begin
                  mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
               end
            end
         end

         case (state_q)
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q  <= ST_DATA;
                  hready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            ST_ERR1: begin
               state_q  <= ST_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= RESP_ERROR;
            end

            // IDLE, DATA and ERR2 all present HREADY=1, so a new address phase is sampled here.
            default: begin
               if (active_c && legal_c) begin
                  wr_q    <= HWRITE;
                  idx_q   <= HADDR[IDX_W+1:2];
                  lanes_q <= lanes_c;
                  hresp_q <= RESP_OKAY;
                  if (WAIT_STATES > 0) begin
                     state_q  <= ST_WAIT;
                     hready_q <= 1'b0;
                     cnt_q    <= WAIT_LOAD;
                  end else begin
                     state_q  <= ST_DATA;
                     hready_q <= 1'b1;
                  end
               end else if (active_c) begin
                  wr_q     <= 1'b0;
                  state_q  <= ST_ERR1;
                  hready_q <= 1'b0;
                  hresp_q  <= RESP_ERROR;
               end else begin
                  wr_q     <= 1'b0;
                  state_q  <= ST_IDLE;
                  hready_q <= 1'b1;
                  hresp_q  <= RESP_OKAY;
               end
            end
         endcase
      end
   end

   // Read data is driven only during a read data phase; zero otherwise.
   assign HRDATA = (state_q == ST_DATA && !wr_q) ? mem_q[idx_q] : '0;
   assign HREADY = hready_q;
   assign HRESP  = hresp_q;

endmodule
